// File: rtl/encoder_position_tracker.sv
// Quadrature direction code -> step events, signed position, windowed velocity and motion state.
// Optional encoder index (Z) handling is enabled with the ENCODER_INDEX_EN macro.
module encoder_position_tracker #(
  parameter int POS_WIDTH     = 16,
  parameter int VEL_WIDTH     = 12,
  parameter int WINDOW_CYCLES = 50000,
  parameter int SATURATE      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  dir,
  input  logic                        clear,
`ifdef ENCODER_INDEX_EN
  input  logic                        index,
  output logic                        index_seen,
`endif
  output logic signed [POS_WIDTH-1:0] position,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        step_valid,
  output logic                        step_ccw,
  output logic [1:0]                  motion,
  output logic                        dir_error
);

  typedef enum logic [1:0] {
    STOPPED    = 2'b00,
    MOVING_CW  = 2'b01,
    MOVING_CCW = 2'b10
  } state_t;

  localparam int CNT_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic signed [VEL_WIDTH-1:0] VEL_MAX = {1'b0, {(VEL_WIDTH-1){1'b1}}};
  localparam logic signed [VEL_WIDTH-1:0] VEL_MIN = {1'b1, {(VEL_WIDTH-1){1'b0}}};

  state_t                        state;
  logic [1:0]                    dir_q;
  logic                          prime;
  logic [CNT_W-1:0]              win_cnt;
  logic signed [VEL_WIDTH-1:0]   acc;
  logic signed [VEL_WIDTH-1:0]   acc_next;
  logic signed [POS_WIDTH-1:0]   pos_next;
  logic                          cw, ccw, terminal, zero_pos;

  // A held dir code counts once; the prime cycle only seeds dir_q.
  assign cw       = !prime && (dir == 2'b01) && (dir_q != 2'b01);
  assign ccw      = !prime && (dir == 2'b10) && (dir_q != 2'b10);
  assign terminal = (win_cnt == CNT_W'(WINDOW_CYCLES - 1));
  assign motion   = state;

`ifdef ENCODER_INDEX_EN
  logic index_q;
  logic index_rise;
  assign index_rise = index && !index_q;
  assign zero_pos   = clear || index_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q    <= 1'b0;
      index_seen <= 1'b0;
    end else begin
      index_q <= index;
      if (index_rise) index_seen <= 1'b1;
    end
  end
`else
  assign zero_pos = clear;
`endif

  always_comb begin
    pos_next = position;
    if (cw) begin
      if (!(SATURATE != 0 && position == POS_MAX)) pos_next = position + POS_WIDTH'(1);
    end else if (ccw) begin
      if (!(SATURATE != 0 && position == POS_MIN)) pos_next = position - POS_WIDTH'(1);
    end
    if (zero_pos) pos_next = '0;
  end

  always_comb begin
    acc_next = acc;
    if (cw && acc != VEL_MAX)       acc_next = acc + VEL_WIDTH'(1);
    else if (ccw && acc != VEL_MIN) acc_next = acc - VEL_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q      <= 2'b00;
      prime      <= 1'b1;
      position   <= '0;
      step_valid <= 1'b0;
      step_ccw   <= 1'b0;
      dir_error  <= 1'b0;
      win_cnt    <= '0;
      acc        <= '0;
      velocity   <= '0;
      state      <= STOPPED;
    end else begin
      dir_q      <= dir;
      prime      <= 1'b0;
      position   <= pos_next;
      step_valid <= cw || ccw;
      if (cw || ccw) step_ccw <= ccw;
      if (dir == 2'b11) dir_error <= 1'b1;

      if (terminal) begin
        win_cnt  <= '0;
        velocity <= acc_next;
        acc      <= '0;
      end else begin
        win_cnt <= win_cnt + CNT_W'(1);
        acc     <= acc_next;
      end

      // A reversal wins over a stop decision in the same cycle.
      case (state)
        STOPPED: begin
          if (cw)       state <= MOVING_CW;
          else if (ccw) state <= MOVING_CCW;
        end
        MOVING_CW: begin
          if (ccw)                             state <= MOVING_CCW;
          else if (terminal && acc_next == '0) state <= STOPPED;
        end
        MOVING_CCW: begin
          if (cw)                              state <= MOVING_CW;
          else if (terminal && acc_next == '0) state <= STOPPED;
        end
        default: state <= STOPPED;
      endcase
    end
  end

endmodule
